// File: rtl/dmem_lsu.sv
// -----------------------------------------------------------------------------
// dmem_lsu
// Load/store initiator for the single-word data memory port. Takes one scalar
// (1 word) or vector (LANES words) request per handshake, serialises it into
// per-word memory accesses in ascending address order, and returns a single
// response with assembled load data or a completion/error status.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   req_valid/ready     request handshake (ready only while idle)
//   req_we, req_vec     store/load select, vector/scalar select
//   req_addr            base word address
//   req_wdata           store data, lane i in bits [S*i +: S]
//   resp_valid/ready    response handshake
//   resp_err            request rejected: addressed words fall outside SIZE
//   resp_rdata          load data (zero for stores and errors)
//   mem_we/addr/wdata   memory write strobe, word address, write word
//   mem_rdata           memory read word, valid the cycle after mem_addr
// -----------------------------------------------------------------------------
module dmem_lsu #(
    parameter int S     = 32,
    parameter int LANES = 6,
    parameter int V     = 192,
    parameter int SIZE  = 14
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_we,
    input  logic         req_vec,
    input  logic [S-1:0] req_addr,
    input  logic [V-1:0] req_wdata,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic         resp_err,
    output logic [V-1:0] resp_rdata,
    output logic         mem_we,
    output logic [S-1:0] mem_addr,
    output logic [S-1:0] mem_wdata,
    input  logic [S-1:0] mem_rdata
);

    localparam int IW = $clog2(LANES);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        RD_DRAIN,
        RESP
    } state_t;

    state_t          r_state;
    logic            r_req_ready;
    logic            r_resp_valid;
    logic            r_resp_err;
    logic [V-1:0]    r_resp_rdata;
    logic            r_mem_we;
    logic [S-1:0]    r_mem_addr;
    logic [S-1:0]    r_mem_wdata;
    logic [IW-1:0]   r_idx;
    logic [IW-1:0]   r_last;
    logic [V-1:0]    r_wdata;

    logic [S:0]      w_span;
    logic [S:0]      w_last_addr;
    logic            w_range_err;
    logic [IW-1:0]   w_idx_next;
    logic [IW-1:0]   w_cap_idx;
    logic [S-1:0]    w_next_lane;
    logic [V-1:0]    w_rdata_cap;

    // Range check is done one bit wider so a base near the top of the address
    // space that wraps past zero is still reported as out of range.
    assign w_span      = req_vec ? (S+1)'(LANES - 1) : '0;
    assign w_last_addr = {1'b0, req_addr} + w_span;
    assign w_range_err = (w_last_addr >= (S+1)'(SIZE));

    assign w_idx_next  = r_idx + 1'b1;
    // Read data lags the address by one cycle: in RD the returning word
    // belongs to the previous lane, in RD_DRAIN it belongs to the last lane.
    assign w_cap_idx   = (r_state == RD_DRAIN) ? r_idx : r_idx - 1'b1;

    always_comb begin
        w_next_lane = '0;
        for (int i = 0; i < LANES; i++) begin
            if (w_idx_next == IW'(i)) begin
                w_next_lane = r_wdata[i*S +: S];
            end
        end
    end

    always_comb begin
        w_rdata_cap = r_resp_rdata;
        for (int i = 0; i < LANES; i++) begin
            if (w_cap_idx == IW'(i)) begin
                w_rdata_cap[i*S +: S] = mem_rdata;
            end
        end
    end

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples the pre-edge values of its neighbours, independent of
    // statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_idx        <= '0;
            r_last       <= '0;
            r_wdata      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_req_ready  <= 1'b0;
                        r_resp_rdata <= '0;
                        r_wdata      <= req_wdata;
                        r_last       <= req_vec ? IW'(LANES - 1) : '0;
                        r_idx        <= '0;
                        r_mem_addr   <= req_addr;
                        r_mem_wdata  <= req_wdata[S-1:0];
                        r_resp_err   <= w_range_err;
                        if (w_range_err) begin
                            r_resp_valid <= 1'b1;
                            r_state      <= RESP;
                        end else if (req_we) begin
                            r_mem_we <= 1'b1;
                            r_state  <= WR;
                        end else begin
                            r_state  <= RD;
                        end
                    end
                end
                WR: begin
                    if (r_idx == r_last) begin
                        r_mem_we     <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_state      <= RESP;
                    end else begin
                        r_idx       <= w_idx_next;
                        r_mem_addr  <= r_mem_addr + 1'b1;
                        r_mem_wdata <= w_next_lane;
                    end
                end
                RD: begin
                    if (r_idx != '0) begin
                        r_resp_rdata <= w_rdata_cap;
                    end
                    if (r_idx == r_last) begin
                        r_state <= RD_DRAIN;
                    end else begin
                        r_idx      <= w_idx_next;
                        r_mem_addr <= r_mem_addr + 1'b1;
                    end
                end
                RD_DRAIN: begin
                    r_resp_rdata <= w_rdata_cap;
                    r_resp_valid <= 1'b1;
                    r_state      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_state      <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_req_ready <= 1'b1;
                    r_mem_we    <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_err   = r_resp_err;
    assign resp_rdata = r_resp_rdata;
    // Gating with rst keeps the strobe low from the instant reset asserts,
    // independent of how the register's async clear is implemented.
    assign mem_we     = r_mem_we && !rst;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_dmem_lsu.sv
// -----------------------------------------------------------------------------
// tb_dmem_lsu
// Self-checking bench for dmem_lsu. A small synchronous-read memory model sits
// on the memory port and logs every write strobe. A table of directed
// requests with hand-computed responses and latencies is run back to back,
// followed by hand-written sequences for response backpressure and reset in
// the middle of a vector store.
// -----------------------------------------------------------------------------
module tb_dmem_lsu;

    localparam int S     = 32;
    localparam int LANES = 6;
    localparam int V     = 192;
    localparam int SIZE  = 14;

    logic         clk;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic         req_we;
    logic         req_vec;
    logic [S-1:0] req_addr;
    logic [V-1:0] req_wdata;
    logic         resp_valid;
    logic         resp_ready;
    logic         resp_err;
    logic [V-1:0] resp_rdata;
    logic         mem_we;
    logic [S-1:0] mem_addr;
    logic [S-1:0] mem_wdata;
    logic [S-1:0] mem_rdata;

    dmem_lsu #(.S(S), .LANES(LANES), .V(V), .SIZE(SIZE)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_vec    (req_vec),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_err   (resp_err),
        .resp_rdata (resp_rdata),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: write on strobe, read data returned the following cycle.
    logic [S-1:0] mem [SIZE];
    logic [S-1:0] wq_addr [$];
    logic [S-1:0] wq_data [$];

    initial begin
        for (int i = 0; i < SIZE; i++) mem[i] = '0;
        mem_rdata = '0;
    end

    always @(posedge clk) begin
        if (mem_we) begin
            wq_addr.push_back(mem_addr);
            wq_data.push_back(mem_wdata);
            if (mem_addr < SIZE) mem[mem_addr[3:0]] <= mem_wdata;
        end
        mem_rdata <= (mem_addr < SIZE) ? mem[mem_addr[3:0]] : '0;
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [V-1:0] got, input logic [V-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic         we;
        logic         vec;
        logic [S-1:0] addr;
        logic [V-1:0] wdata;
        logic         err;
        logic [V-1:0] rdata;
        int           lat;
    } vec_t;

    function automatic logic [V-1:0] lanes6(input logic [S-1:0] l0, input logic [S-1:0] l1,
                                            input logic [S-1:0] l2, input logic [S-1:0] l3,
                                            input logic [S-1:0] l4, input logic [S-1:0] l5);
        return {l5, l4, l3, l2, l1, l0};
    endfunction

    // Issue one request with resp_ready held high and check the response,
    // its latency from the acceptance edge, and the exact write sequence.
    task automatic do_req(input vec_t t, input string tag);
        int k;
        int n_exp;
        bit order_ok;
        check({tag, "_req_ready"}, V'(req_ready), V'(1));
        wq_addr.delete();
        wq_data.delete();
        req_valid  = 1'b1;
        req_we     = t.we;
        req_vec    = t.vec;
        req_addr   = t.addr;
        req_wdata  = t.wdata;
        resp_ready = 1'b1;
        tick();
        // Scramble the request fields after acceptance.
        req_valid = 1'b0;
        req_we    = ~t.we;
        req_vec   = ~t.vec;
        req_addr  = '1;
        req_wdata = '1;
        k = 1;
        while (!resp_valid && k < 20) begin
            tick();
            k++;
        end
        check({tag, "_resp_valid"}, V'(resp_valid), V'(1));
        check({tag, "_latency"}, V'(k), V'(t.lat));
        check({tag, "_err"}, V'(resp_err), V'(t.err));
        check({tag, "_rdata"}, resp_rdata, t.rdata);
        n_exp = (t.we && !t.err) ? (t.vec ? LANES : 1) : 0;
        check({tag, "_nwrites"}, V'(wq_addr.size()), V'(n_exp));
        order_ok = 1'b1;
        for (int i = 0; i < n_exp && i < wq_addr.size(); i++) begin
            if (wq_addr[i] !== t.addr + S'(i) || wq_data[i] !== t.wdata[i*S +: S]) order_ok = 1'b0;
        end
        check({tag, "_write_order"}, V'(order_ok), V'(1));
        tick();
        check({tag, "_resp_done"}, V'(resp_valid), V'(0));
    endtask

    vec_t tbl [11];
    logic [V-1:0] held;

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_vec    = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b1;

        tbl[0]  = '{1'b1, 1'b1, 32'd2, lanes6(32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66), 1'b0, '0, 7};
        tbl[1]  = '{1'b0, 1'b1, 32'd2, '0, 1'b0, lanes6(32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66), 8};
        tbl[2]  = '{1'b1, 1'b0, 32'd5, V'(32'hDEADBEEF), 1'b0, '0, 2};
        tbl[3]  = '{1'b0, 1'b0, 32'd5, '0, 1'b0, V'(32'hDEADBEEF), 3};
        tbl[4]  = '{1'b0, 1'b1, 32'd9, '0, 1'b1, '0, 1};
        tbl[5]  = '{1'b1, 1'b1, 32'd8, lanes6(32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA5), 1'b0, '0, 7};
        tbl[6]  = '{1'b0, 1'b1, 32'd8, '0, 1'b0, lanes6(32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA5), 8};
        tbl[7]  = '{1'b1, 1'b1, 32'hFFFF_FFFE, lanes6(32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6), 1'b1, '0, 1};
        tbl[8]  = '{1'b0, 1'b0, 32'd13, '0, 1'b0, V'(32'hA5), 3};
        tbl[9]  = '{1'b1, 1'b0, 32'd14, V'(32'h77), 1'b1, '0, 1};
        tbl[10] = '{1'b0, 1'b1, 32'd2, '0, 1'b0, lanes6(32'h11, 32'h22, 32'h33, 32'hDEADBEEF, 32'h55, 32'h66), 8};

        // Reset state.
        #2;
        check("rst_req_ready", V'(req_ready), V'(1));
        check("rst_resp_valid", V'(resp_valid), V'(0));
        check("rst_resp_err", V'(resp_err), V'(0));
        check("rst_resp_rdata", resp_rdata, '0);
        check("rst_mem_we", V'(mem_we), V'(0));
        check("rst_mem_addr", V'(mem_addr), V'(0));
        check("rst_mem_wdata", V'(mem_wdata), V'(0));
        tick();
        tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 11; i++) begin
            do_req(tbl[i], $sformatf("vec%0d", i));
        end

        // Response backpressure during a vector load, with a competing request.
        wq_addr.delete();
        wq_data.delete();
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_vec    = 1'b1;
        req_addr   = 32'd2;
        resp_ready = 1'b0;
        tick();
        req_valid = 1'b0;
        begin
            int k;
            k = 1;
            while (!resp_valid && k < 20) begin
                tick();
                k++;
            end
            check("bp_latency", V'(k), V'(8));
        end
        held = lanes6(32'h11, 32'h22, 32'h33, 32'hDEADBEEF, 32'h55, 32'h66);
        check("bp_rdata", resp_rdata, held);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_vec   = 1'b0;
        req_addr  = 32'd0;
        req_wdata = V'(32'h99);
        for (int c = 0; c < 4; c++) begin
            tick();
            check($sformatf("bp_hold%0d_valid", c), V'(resp_valid), V'(1));
            check($sformatf("bp_hold%0d_rdata", c), resp_rdata, held);
            check($sformatf("bp_hold%0d_req_ready", c), V'(req_ready), V'(0));
        end
        resp_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        check("bp_after_valid", V'(resp_valid), V'(0));
        check("bp_after_req_ready", V'(req_ready), V'(1));
        tick();
        check("bp_ignored_writes", V'(wq_addr.size()), V'(0));
        check("bp_mem0", V'(mem[0]), V'(0));

        // Reset during the third write cycle of a vector store at base 2.
        wq_addr.delete();
        wq_data.delete();
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_vec   = 1'b1;
        req_addr  = 32'd2;
        req_wdata = lanes6(32'hC0, 32'hC1, 32'hC2, 32'hC3, 32'hC4, 32'hC5);
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        check("rstmid_we_before", V'(mem_we), V'(1));
        check("rstmid_addr_before", V'(mem_addr), V'(4));
        #2 rst = 1'b1;
        #1;
        check("rstmid_we_drop", V'(mem_we), V'(0));
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rstmid_req_ready", V'(req_ready), V'(1));
        check("rstmid_resp_valid", V'(resp_valid), V'(0));
        for (int c = 0; c < 8; c++) tick();
        check("rstmid_nwrites", V'(wq_addr.size()), V'(2));
        check("rstmid_mem5", V'(mem[5]), V'(32'hDEADBEEF));
        check("rstmid_mem6", V'(mem[6]), V'(32'h55));
        check("rstmid_mem7", V'(mem[7]), V'(32'h66));
        check("rstmid_idle_valid", V'(resp_valid), V'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit so a stuck design cannot hang the run.
    initial begin
        #200000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Load/store initiator that drives the single-word data memory port on behalf of the vector pipeline.
- Accepts one scalar (32-bit) or vector (6x32-bit lanes, 192-bit) load/store request per handshake.
- Serialises each request into per-word memory accesses and returns a single response with assembled read data or a completion/error status.
- Sits between the MEM pipeline stage and the data memory.

Parameters:
- S, 32, address width and memory word width.
- V, 192, vector data width (LANES*S).
- LANES, 6, words per vector access.
- SIZE, 14, memory depth in words, used for range checking.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous active-high reset
- req_valid  input  1  request present
- req_ready  output  1  LSU can accept a request
- req_we  input  1  1=store, 0=load
- req_vec  input  1  1=vector (LANES words), 0=scalar (1 word)
- req_addr  input  S  base word address
- req_wdata  input  V  store data; lane i = bits [32i+31:32i]; scalar uses [31:0]
- resp_valid  output  1  response available
- resp_ready  input  1  pipeline consumes response
- resp_err  output  1  request rejected (out of range)
- resp_rdata  output  V  load data
- mem_we  output  1  memory write strobe
- mem_addr  output  S  memory word address
- mem_wdata  output  S  memory write word
- mem_rdata  input  S  memory read word, valid the cycle after mem_addr is presented

Behaviour:
- Reset (async, immediate): state IDLE; req_ready=1; resp_valid=0, resp_err=0, resp_rdata=0; mem_we=0, mem_addr=0, mem_wdata=0; lane counter=0.
- mem_we must drop combinationally on rst assertion. A request in flight is abandoned, with no further writes and no response.
- States: IDLE, WR, RD, RD_DRAIN, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, capture we/vec/addr/wdata. Set n=LANES if vec, else 1.
  - If addr+n-1 >= SIZE (compute in S+1 bits, so wrap-around counts as out of range): go to RESP with resp_err=1, rdata=0, and no memory access.
  - Else go to WR (store) or RD (load), with idx=0.
- req_ready=0 in every state except IDLE. No new request is accepted while a response is pending.
- WR:
  - Each cycle: mem_we=1, mem_addr=base+idx, mem_wdata=lane idx.
  - After idx=n-1, go to RESP with resp_err=0.
  - Scalar store occupies 1 cycle, vector store 6 cycles, lanes in ascending address order.
- RD:
  - Each cycle: mem_we=0, mem_addr=base+idx.
  - The lane idx-1 word is captured from mem_rdata when idx>0.
  - After issuing idx=n-1, go to RD_DRAIN.
- RD_DRAIN: capture lane n-1, go to RESP. Scalar load zero-fills resp_rdata[V-1:32].
- RESP:
  - resp_valid=1; resp_rdata/resp_err held stable until resp_valid&&resp_ready, then go to IDLE.
  - resp_ready held high gives a one-cycle response.
  - Store responses carry resp_rdata=0.
- Outside WR, mem_we=0. mem_addr/mem_wdata are don't-care but must be driven.
- Latency, acceptance edge = cycle 0, resp_ready=1:
  - scalar store: mem_we in cycle 1, resp_valid in cycle 2.
  - vector store: mem_we in cycles 1–6, resp_valid in cycle 7.
  - scalar load: resp_valid in cycle 3.
  - vector load: resp_valid in cycle 8.
  - error: resp_valid in cycle 1.
- Back-to-back: a new request can be accepted the cycle after the response handshake completes.
- Request fields may change after acceptance without affecting the current operation.

Test Plan:
- Reset mid vector store, asserted during the 3rd write cycle: mem_we falls immediately, no further writes. After release, req_ready=1, resp_valid=0, and memory words base+3..base+5 are unchanged.
- Vector store at addr 2, lanes 0x11..0x66: mem_we for 6 cycles with addr 2..7 and data 0x11..0x66 in order, resp_valid in cycle 7 with resp_err=0. Then a vector load at addr 2 returns resp_rdata={0x66,0x55,0x44,0x33,0x22,0x11} in cycle 8.
- Scalar load at addr 5 after word 0xDEADBEEF is stored there: resp_rdata=160'b0 concatenated with 0xDEADBEEF, resp_valid in cycle 3.
- Vector load at addr 9 with SIZE=14 (9+5=14): resp_err=1, resp_rdata=0, mem_we never asserted, resp_valid in cycle 1. Vector at addr 8 (last word 13) succeeds. Addr 0xFFFFFFFE vector errors (wrap).
- resp_ready held low for 4 cycles during a load response: resp_valid and resp_rdata stay stable, req_ready=0, and a new req_valid is ignored until the handshake completes.
- Back-to-back scalar store then scalar load to the same address with resp_ready=1: the load returns the stored value, with the second acceptance in the cycle after the first response.
